branch_unit: RTL



---
 rtl/branch_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
//
// Branch resolution and prediction unit for the multicycle RISC-V core.
// The fetch state looks up a direction prediction from a direct-mapped table
// of 2-bit saturating counters. The execute state resolves B-type branches
// with full-width compares, trains the table, flags mispredictions and keeps
// saturating statistics.
//
// Ports
//   i_clk             system clock, rising edge
//   i_rst_n           asynchronous active-low reset
//   i_pred_req        prediction lookup request
//   i_pred_pc         PC of the instruction being fetched
//   o_pred_valid      one-cycle pulse, prediction result valid
//   o_pred_taken      predicted direction (MSB of the indexed counter)
//   i_res_valid       resolve request
//   i_res_op          instruction opcode
//   i_res_funct3      instruction funct3
//   i_res_pc          PC of the resolving instruction
//   i_rs1, i_rs2      compare operands
//   i_res_pred_taken  direction predicted earlier for this instruction
//   o_res_done        one-cycle pulse, resolve result valid
//   o_res_taken       actual branch outcome
//   o_res_mispredict  outcome differs from prediction
//   o_illegal_branch  branch opcode with reserved funct3
//   i_stats_clr       synchronous clear of the statistics counters
//   o_branch_cnt      resolved legal branches (saturating)
//   o_mispredict_cnt  mispredicted legal branches (saturating)
// -----------------------------------------------------------------------------
module branch_unit #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 16,
  parameter logic [1:0] CNT_INIT  = 2'b01,
  parameter int         STAT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pred_req,
  input  logic [XLEN-1:0]   i_pred_pc,
  output logic              o_pred_valid,
  output logic              o_pred_taken,
  input  logic              i_res_valid,
  input  logic [6:0]        i_res_op,
  input  logic [2:0]        i_res_funct3,
  input  logic [XLEN-1:0]   i_res_pc,
  input  logic [XLEN-1:0]   i_rs1,
  input  logic [XLEN-1:0]   i_rs2,
  input  logic              i_res_pred_taken,
  output logic              o_res_done,
  output logic              o_res_taken,
  output logic              o_res_mispredict,
  output logic              o_illegal_branch,
  input  logic              i_stats_clr,
  output logic [STAT_W-1:0] o_branch_cnt,
  output logic [STAT_W-1:0] o_mispredict_cnt
);

  localparam int         IDX_W     = $clog2(BHT_DEPTH);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [1:0]        r_bht [BHT_DEPTH];
  logic              r_pred_valid;
  logic              r_pred_taken;
  logic              r_res_done;
  logic              r_res_taken;
  logic              r_res_mispredict;
  logic              r_illegal_branch;
  logic [STAT_W-1:0] r_branch_cnt;
  logic [STAT_W-1:0] r_mispredict_cnt;

  logic [IDX_W-1:0]  w_pred_idx;
  logic [IDX_W-1:0]  w_res_idx;
  logic              w_is_branch;
  logic              w_reserved_f3;
  logic              w_legal;
  logic              w_cond;
  logic              w_mispredict;
  logic              w_update;
  logic [1:0]        w_ctr_old;
  logic [1:0]        w_ctr_new;
  logic              w_unused_pc;

  // Word-aligned PCs: bits [1:0] never participate in the index and upper
  // bits are dropped, so distinct PCs may alias onto one counter.
  assign w_pred_idx  = i_pred_pc[IDX_W+1:2];
  assign w_res_idx   = i_res_pc[IDX_W+1:2];
  assign w_unused_pc = ^{i_pred_pc[XLEN-1:IDX_W+2], i_pred_pc[1:0],
                         i_res_pc[XLEN-1:IDX_W+2], i_res_pc[1:0]};

  assign w_is_branch   = (i_res_op == OP_BRANCH);
  assign w_reserved_f3 = (i_res_funct3 == 3'b010) || (i_res_funct3 == 3'b011);
  assign w_legal       = w_is_branch && !w_reserved_f3;

  // Full-width condition evaluation for the six B-type compares.
  always_comb begin
    w_cond = 1'b0;
    unique case (i_res_funct3)
      3'b000:  w_cond = (i_rs1 == i_rs2);
      3'b001:  w_cond = (i_rs1 != i_rs2);
      3'b100:  w_cond = ($signed(i_rs1) <  $signed(i_rs2));
      3'b101:  w_cond = ($signed(i_rs1) >= $signed(i_rs2));
      3'b110:  w_cond = (i_rs1 <  i_rs2);
      3'b111:  w_cond = (i_rs1 >= i_rs2);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_mispredict = w_cond ^ i_res_pred_taken;
  assign w_update     = i_res_valid && w_legal;

  // Next value of the trained counter, saturating at 0 and 3.
  assign w_ctr_old = r_bht[w_res_idx];
  always_comb begin
    w_ctr_new = w_ctr_old;
    if (w_cond) begin
      if (w_ctr_old != 2'b11) w_ctr_new = w_ctr_old + 2'b01;
    end else begin
      if (w_ctr_old != 2'b00) w_ctr_new = w_ctr_old - 2'b01;
    end
  end

  // Counter table. A lookup in the same cycle as an update reads the
  // registered (pre-update) value, giving read-before-write naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= CNT_INIT;
    end else if (w_update) begin
      r_bht[w_res_idx] <= w_ctr_new;
    end
  end

  // Prediction pipeline stage. Direction is forced low when no result is
  // presented so the output is clean between pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
    end else begin
      r_pred_valid <= i_pred_req;
      r_pred_taken <= i_pred_req & r_bht[w_pred_idx][1];
    end
  end

  // Resolve pipeline stage. Only legal branches may report taken or
  // mispredicted; reserved funct3 only raises the illegal flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res_done       <= 1'b0;
      r_res_taken      <= 1'b0;
      r_res_mispredict <= 1'b0;
      r_illegal_branch <= 1'b0;
    end else begin
      r_res_done       <= i_res_valid;
      r_res_taken      <= w_update & w_cond;
      r_res_mispredict <= w_update & w_mispredict;
      r_illegal_branch <= i_res_valid & w_is_branch & w_reserved_f3;
    end
  end

  // Statistics: clear has priority over a coincident increment, and both
  // counters stick at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (i_stats_clr) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (w_update) begin
      if (r_branch_cnt != '1)
        r_branch_cnt <= r_branch_cnt + STAT_W'(1);
      if (w_mispredict && (r_mispredict_cnt != '1))
        r_mispredict_cnt <= r_mispredict_cnt + STAT_W'(1);
    end
  end

  assign o_pred_valid     = r_pred_valid;
  assign o_pred_taken     = r_pred_taken;
  assign o_res_done       = r_res_done;
  assign o_res_taken      = r_res_taken;
  assign o_res_mispredict = r_res_mispredict;
  assign o_illegal_branch = r_illegal_branch;
  assign o_branch_cnt     = r_branch_cnt;
  assign o_mispredict_cnt = r_mispredict_cnt;

endmodule
